linear_1d_hs_tx: RTL and testbench
==================================

# linear_1d_hs_tx

Source-side initiator of a four-phase req/ack handshake used to move a data word into another clock domain. It accepts one word on a valid/ready interface, holds it stable on `tx_data` while driving `tx_req`, and synchronizes the returning `tx_ack` through an internal multi-flop chain. It is the transmitting end for a receiver that samples `tx_req` through a synchronizer. It sits in the linear_1d datapath wherever a control or parameter word leaves the `clk` domain.

## Interface
- `DATA_WIDTH`, 32: width of `in_data` and `tx_data`.
- `CYCLES`, 2: number of flops in the `tx_ack` synchronizer chain; must be ≥ 2.
- `TIMEOUT`, 1024: number of cycles the FSM waits in a handshake state before aborting. Used only with `LINEAR_1D_HS_TX_TIMEOUT_EN`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk`  in  1  single clock; all state is in this domain.
- `in_valid`  in  1  source offers a word.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  DATA_WIDTH  word to transfer.
- `tx_req`  out  1  request level to the far domain; registered.
- `tx_data`  out  DATA_WIDTH  held word; registered; stable whenever `tx_req`=1.
- `tx_ack`  in  1  acknowledge level from the far domain; asynchronous to `clk`.
- `busy`  out  1  a handshake is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when a handshake completes normally.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation
- Ack synchronizer: `CYCLES` flops, reset to 0. `ack_s` is the output of the last flop. The FSM uses only `ack_s`.
- FSM states: IDLE, REQ, RELEASE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`=1, capture `in_data` into `tx_data`, set `tx_req`←1, go to REQ.
- REQ:
  - `in_ready`=0; `tx_req` is held at 1.
  - When `ack_s`=1: set `tx_req`←0, go to RELEASE.
- RELEASE:
  - `in_ready`=0.
  - When `ack_s`=0: go to IDLE and pulse `done` for one cycle. A completion after a timeout abort does not pulse `done`.
- `tx_data` changes only on acceptance in IDLE. It keeps its value after completion.
- `ack_s` high while in IDLE (a stale or glitched ack): ignored, and it does not block acceptance. A following REQ then completes as soon as the synchronized ack is seen.
- `err_clr`=1 clears `err` on the next edge. If a timeout and `err_clr` happen in the same cycle, set wins.

## Timing
- Reset values: `tx_req`=0, `tx_data`=0, `busy`=0, `done`=0, `err`=0, `in_ready`=1 (combinational from IDLE), synchronizer flops=0, state=IDLE.
- Acceptance at edge k:
  - `tx_req`=1 and `tx_data`=word from cycle k+1.
  - `busy`=1 from cycle k+1.
- `tx_ack` rising before edge j:
  - `ack_s`=1 after edge j+CYCLES-1.
  - `tx_req` falls one edge later.
- `tx_ack` falling: the same CYCLES-edge delay, then IDLE and `done` one edge later.
- Minimum accept-to-accept interval with an immediately responding receiver: 2·CYCLES+3 cycles.
- Reset asserted mid-handshake: every output returns to its reset value immediately (asynchronously). `tx_req` drops regardless of `tx_ack`. The receiver must tolerate this abandoned request.

## Configuration
- `LINEAR_1D_HS_TX_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to REQ or RELEASE and increments every cycle spent there.
  - In REQ, when the counter reaches `TIMEOUT`: set `err`, set `tx_req`←0, go to RELEASE; no `done` pulse follows.
  - In RELEASE, when the counter reaches `TIMEOUT`: set `err`, force IDLE, no `done` pulse.
- `LINEAR_1D_HS_TX_TIMEOUT_EN` undefined:
  - No counter is built; `err` is tied to 0 and `err_clr` is ignored.
  - The FSM waits indefinitely in REQ and RELEASE.

## Test plan
- Single transfer, CYCLES=2, receiver acks 3 cycles after `tx_req` rises and drops ack 3 cycles after `tx_req` falls, `in_data`=0xA5A5_0001. Required: `tx_data`=0xA5A5_0001 stable throughout `tx_req`=1, exactly one `done` pulse, `in_ready` returns to 1.
- Back-to-back with `in_valid` held high and words 1, 2, 3. Required: three handshakes in order, no word lost or duplicated, `in_ready`=0 between acceptances.
- Ack latency: `tx_ack` pulled high at a known edge. Required: `tx_req` falls exactly CYCLES+1 edges later, checked for CYCLES=2 and CYCLES=4.
- Reset asserted while in REQ. Required: `tx_req`, `busy`, `tx_data` go to 0 without waiting for a clock edge; after release, a new word transfers normally.
- With the macro defined and TIMEOUT=16, `tx_ack` held at 0. Required: `tx_req` drops after 16 cycles, `err`=1, no `done`, block returns to IDLE; `err_clr` pulse → `err`=0.
- Without the macro, `tx_ack` held at 0 for 5000 cycles. Required: `tx_req` stays 1 and `err` stays 0.

Source files
------------

// File: rtl/linear_1d_hs_tx.sv
// linear_1d_hs_tx: source side of a four-phase req/ack handshake that carries one data word
// into another clock domain. The returning tx_ack is brought in through a CYCLES-deep
// synchronizer. Optional timeout/abort logic is built when LINEAR_1D_HS_TX_TIMEOUT_EN is defined.
module linear_1d_hs_tx #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CYCLES     = 2,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  tx_req,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic                  err_clr
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   logic [CYCLES-1:0]     r_ack_sync;
   logic                  w_ack_s;
   logic [1:0]            r_state;
   logic [1:0]            w_state_d;
   logic                  r_tx_req;
   logic                  w_tx_req_d;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [DATA_WIDTH-1:0] w_tx_data_d;
   logic                  r_done;
   logic                  w_done_d;
   logic                  w_timeout;
   logic                  w_abort;
   logic                  w_accept;

   // Shift the asynchronous ack through the synchronizer chain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ack_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[CYCLES-2:0], tx_ack};
      end
   end

   assign w_ack_s  = r_ack_sync[CYCLES-1];
   assign w_accept = (r_state == ST_IDLE) && in_valid;

`ifdef LINEAR_1D_HS_TX_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             r_abort;

   // The last cycle allowed in a handshake state is the one where the count reads TIMEOUT-1
   assign w_timeout = (r_state != ST_IDLE) && (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_abort   = r_abort;
   assign err       = r_err;

   // Dwell counter: clears on every state change, counts while in REQ or RELEASE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_state_d != r_state) begin
         r_cnt <= '0;
      end else if (r_state != ST_IDLE) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Sticky error flag (a new timeout beats a simultaneous clear) and abort marker
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err   <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         if (w_timeout) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
         if (w_accept) begin
            r_abort <= 1'b0;
         end else if (w_timeout && (r_state == ST_REQ)) begin
            r_abort <= 1'b1;
         end
      end
   end
`else
   logic w_unused_cfg;

   assign w_timeout    = 1'b0;
   assign w_abort      = 1'b0;
   assign err          = 1'b0;
   assign w_unused_cfg = ^{err_clr, TIMEOUT[0]};
`endif

   // Handshake sequencing: IDLE -> REQ (req high) -> RELEASE (req low) -> IDLE
   always_comb begin
      w_state_d   = r_state;
      w_tx_req_d  = r_tx_req;
      w_tx_data_d = r_tx_data;
      w_done_d    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A stale high ack_s here is deliberately ignored
            if (in_valid) begin
               w_tx_data_d = in_data;
               w_tx_req_d  = 1'b1;
               w_state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (w_ack_s || w_timeout) begin
               w_tx_req_d = 1'b0;
               w_state_d  = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!w_ack_s) begin
               w_state_d = ST_IDLE;
               w_done_d  = !w_abort;
            end else if (w_timeout) begin
               w_state_d = ST_IDLE;
            end
         end
         default: begin
            w_tx_req_d = 1'b0;
            w_state_d  = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_tx_req  <= 1'b0;
         r_tx_data <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_tx_req  <= w_tx_req_d;
         r_tx_data <= w_tx_data_d;
         r_done    <= w_done_d;
      end
   end

   assign in_ready = (r_state == ST_IDLE);
   assign busy     = (r_state != ST_IDLE);
   assign tx_req   = r_tx_req;
   assign tx_data  = r_tx_data;
   assign done     = r_done;

endmodule

// File: tb/tb_linear_1d_hs_tx.sv
// Self-checking bench for linear_1d_hs_tx. The bench acts as the far-domain receiver and
// predicts every output from the handshake rules: a change on tx_ack becomes visible to the
// FSM after C edges and takes effect one edge after that.
module tb_linear_1d_hs_tx;

   localparam int unsigned DW = 32;
   localparam int unsigned C  = 2;
   localparam int unsigned C4 = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          tx_ack = 1'b0;
   logic          err_clr = 1'b0;

   logic          in_ready, tx_req, busy, done, err;
   logic [DW-1:0] tx_data;
   logic          in_ready4, tx_req4, busy4, done4, err4;
   logic [DW-1:0] tx_data4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   linear_1d_hs_tx #(.DATA_WIDTH(DW), .CYCLES(C), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
      .busy(busy), .done(done), .err(err), .err_clr(err_clr)
   );

   linear_1d_hs_tx #(.DATA_WIDTH(DW), .CYCLES(C4), .TIMEOUT(TO)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .tx_req(tx_req4), .tx_data(tx_data4), .tx_ack(tx_ack),
      .busy(busy4), .done(done4), .err(err4), .err_clr(err_clr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      tx_ack  = 1'b0;
      in_valid = 1'b0;
      err_clr = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   // One complete handshake; receiver raises ack d_ack edges after acceptance and
   // drops it d_rel edges after tx_req falls
   task automatic do_transfer(input logic [DW-1:0] w, input int d_ack, input int d_rel,
                              input string tag);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
      in_data  = ~w;
      checks++;
      if ({tx_req, busy, in_ready, done} !== 4'b1100 || tx_data !== w) begin
         failures++;
         $display("FAIL %s accept: req/busy/rdy/done=%b data=%h, required 1100 data=%h",
                  tag, {tx_req, busy, in_ready, done}, tx_data, w);
      end
      for (int i = 0; i < d_ack; i++) begin
         step();
         checks++;
         if ({tx_req, busy, in_ready, done} !== 4'b1100 || tx_data !== w) begin
            failures++;
            $display("FAIL %s wait_ack: req/busy/rdy/done=%b data=%h, required 1100 data=%h",
                     tag, {tx_req, busy, in_ready, done}, tx_data, w);
         end
      end
      tx_ack = 1'b1;
      for (int i = 1; i <= int'(C) + 1; i++) begin
         logic [3:0] exp_v;
         step();
         exp_v = (i <= int'(C)) ? 4'b1100 : 4'b0100;
         checks++;
         if ({tx_req, busy, in_ready, done} !== exp_v || tx_data !== w) begin
            failures++;
            $display("FAIL %s ack_rise+%0d: req/busy/rdy/done=%b data=%h, required %b data=%h",
                     tag, i, {tx_req, busy, in_ready, done}, tx_data, exp_v, w);
         end
      end
      for (int i = 0; i < d_rel; i++) begin
         step();
         checks++;
         if ({tx_req, busy, in_ready, done} !== 4'b0100) begin
            failures++;
            $display("FAIL %s release_wait: req/busy/rdy/done=%b, required 0100",
                     tag, {tx_req, busy, in_ready, done});
         end
      end
      tx_ack = 1'b0;
      for (int i = 1; i <= int'(C) + 1; i++) begin
         logic [3:0] exp_v;
         step();
         exp_v = (i <= int'(C)) ? 4'b0100 : 4'b0011;
         checks++;
         if ({tx_req, busy, in_ready, done} !== exp_v || tx_data !== w) begin
            failures++;
            $display("FAIL %s ack_fall+%0d: req/busy/rdy/done=%b data=%h, required %b data=%h",
                     tag, i, {tx_req, busy, in_ready, done}, tx_data, exp_v, w);
         end
      end
      step();
      checks++;
      if ({tx_req, busy, in_ready, done, err} !== 5'b00100 || tx_data !== w) begin
         failures++;
         $display("FAIL %s after_done: req/busy/rdy/done/err=%b data=%h, required 00100 data=%h",
                  tag, {tx_req, busy, in_ready, done, err}, tx_data, w);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({tx_req, busy, in_ready, done, err} !== 5'b00100 || tx_data !== '0) begin
         failures++;
         $display("FAIL reset_state: req/busy/rdy/done/err=%b data=%h, required 00100 data=0",
                  {tx_req, busy, in_ready, done, err}, tx_data);
      end
      apply_reset();
      checks++;
      if ({tx_req, busy, in_ready, done, err} !== 5'b00100 || tx_data !== '0) begin
         failures++;
         $display("FAIL reset_release: req/busy/rdy/done/err=%b data=%h, required 00100 data=0",
                  {tx_req, busy, in_ready, done, err}, tx_data);
      end
   endtask

   task automatic test_single();
      do_transfer(32'hA5A5_0001, 3, 3, "single");
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         do_transfer($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), "random");
      end
   endtask

   // in_valid held high; receiver mirrors tx_req onto tx_ack every cycle
   task automatic test_back_to_back();
      logic [DW-1:0] words [3];
      int idx = 0;
      int ndone = 0;
      logic acc;
      words[0] = 32'd1;
      words[1] = 32'd2;
      words[2] = 32'd3;
      in_valid = 1'b1;
      in_data  = words[0];
      for (int c = 0; c < 200 && !(idx == 3 && ndone == 3); c++) begin
         acc = in_ready & in_valid;
         step();
         if (acc) begin
            checks++;
            if (tx_data !== words[idx] || tx_req !== 1'b1) begin
               failures++;
               $display("FAIL b2b_word%0d: data=%h req=%b, required data=%h req=1",
                        idx, tx_data, tx_req, words[idx]);
            end
            idx++;
            if (idx < 3) in_data = words[idx];
            else         in_valid = 1'b0;
         end else if (busy) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL b2b_ready_while_busy: in_ready=%b, required 0", in_ready);
            end
         end
         if (done === 1'b1) ndone++;
         tx_ack = tx_req;
      end
      repeat (10) begin
         step();
         if (done === 1'b1) ndone++;
         tx_ack = tx_req;
      end
      checks++;
      if (idx != 3 || ndone != 3 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_totals: accepts=%0d dones=%0d busy=%b rdy=%b, required 3 3 0 1",
                  idx, ndone, busy, in_ready);
      end
      tx_ack = 1'b0;
   endtask

   // Both instances accept together; tx_req must fall CYCLES+1 edges after ack rises
   task automatic test_ack_latency();
      apply_reset();
      in_valid = 1'b1;
      in_data  = 32'h0BAD_F00D;
      step();
      in_valid = 1'b0;
      step();
      tx_ack = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         checks++;
         if (tx_req !== (i < int'(C) + 1) || tx_req4 !== (i < int'(C4) + 1)) begin
            failures++;
            $display("FAIL ack_latency+%0d: req(C=2)=%b req(C=4)=%b, required %b %b", i,
                     tx_req, tx_req4, (i < int'(C) + 1), (i < int'(C4) + 1));
         end
      end
      tx_ack = 1'b0;
      repeat (12) step();
      checks++;
      if (busy !== 1'b0 || busy4 !== 1'b0) begin
         failures++;
         $display("FAIL ack_latency_idle: busy(C=2)=%b busy(C=4)=%b, required 0 0", busy, busy4);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w;
      w = $urandom | 32'h1;
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({tx_req, busy, in_ready, done, err} !== 5'b00100 || tx_data !== '0) begin
         failures++;
         $display("FAIL reset_mid_async: req/busy/rdy/done/err=%b data=%h, required 00100 data=0",
                  {tx_req, busy, in_ready, done, err}, tx_data);
      end
      step();
      step();
      reset_n = 1'b1;
      step();
      do_transfer(~w, 2, 1, "after_reset");
   endtask

`ifdef LINEAR_1D_HS_TX_TIMEOUT_EN
   task automatic test_timeout();
      int seen_done = 0;
      apply_reset();
      in_valid = 1'b1;
      in_data  = 32'h7777_0016;
      step();
      in_valid = 1'b0;
      for (int i = 1; i < int'(TO); i++) begin
         step();
         if (done === 1'b1) seen_done++;
         checks++;
         if (tx_req !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_wait+%0d: req=%b err=%b, required 1 0", i, tx_req, err);
         end
      end
      step();
      checks++;
      if (tx_req !== 1'b0 || err !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_fire: req=%b err=%b busy=%b, required 0 1 1", tx_req, err, busy);
      end
      repeat (4) begin
         step();
         if (done === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done != 0 || busy !== 1'b0 || in_ready !== 1'b1 || err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_idle: dones=%0d busy=%b rdy=%b err=%b, required 0 0 1 1",
                  seen_done, busy, in_ready, err);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_err_clr: err=%b, required 0", err);
      end
   endtask
`else
   task automatic test_timeout();
      int bad = 0;
      apply_reset();
      in_valid = 1'b1;
      in_data  = 32'h5000_5000;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         err_clr = 1'($urandom_range(0, 1));
         step();
         if (tx_req !== 1'b1 || err !== 1'b0 || busy !== 1'b1) bad++;
      end
      err_clr = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL no_timeout_hold: %0d cycles with req!=1/err!=0/busy!=1, required 0", bad);
      end
      apply_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_ack_latency();
      test_reset_mid();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
